test_check_pattern: RTL and testbench
=====================================

# test_check_pattern

Receive-side checker for the test-pattern Ethernet stream (ethertype 0x88B5). It sits behind the Ethernet frame receiver on the far end of the link. For each accepted frame it parses the payload header (type flag, timestamp, three zero bytes, packet index), verifies the incrementing data section, and reports per-frame results and saturating error statistics.

## Interface
Parameters:
- DATA_LENGTH, 64, number of data bytes after the 8-byte payload header.
- DATA_WIDTH, 8, payload beat width; header fields assume 8.
- COUNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_eth_hdr_valid  in  1  frame header valid.
- s_eth_hdr_ready  out  1  header accept; high only in S_IDLE.
- s_eth_dest_mac  in  48  destination MAC (ignored).
- s_eth_src_mac  in  48  source MAC, captured on header accept.
- s_eth_type  in  16  ethertype.
- s_eth_payload_axis_tdata  in  DATA_WIDTH  payload byte.
- s_eth_payload_axis_tvalid  in  1  payload valid.
- s_eth_payload_axis_tready  out  1  high in every state except S_IDLE.
- s_eth_payload_axis_tlast  in  1  last payload beat.
- s_eth_payload_axis_tuser  in  1  frame error flag, sampled on the tlast beat.
- rx_valid  out  1  one-cycle pulse per checked frame.
- rx_ok  out  1  frame passed all checks; valid while rx_valid is high.
- rx_timestamp  out  16  received timestamp.
- rx_packet_index  out  16  received packet index.
- rx_src_mac  out  48  source MAC of the last checked frame.
- good_frame_count  out  COUNT_WIDTH  frames that passed.
- bad_frame_count  out  COUNT_WIDTH  frames that failed.
- byte_error_count  out  COUNT_WIDTH  mismatched data bytes.
- lost_frame_count  out  COUNT_WIDTH  missing packet indices.

## Operation
- A beat is accepted when tvalid and tready are both high. The counter `cnt` advances only on accepted beats and clears on every state change.
- Payload layout: flag 0x07; timestamp LSB then MSB; three bytes of 0x00; packet index LSB then MSB; then DATA_LENGTH bytes.
- States:
  - S_IDLE: on header accept, go to S_TYPE_FLAG if s_eth_type is 0x88B5, else go to S_SKIP.
  - S_SKIP: discard beats until tlast, then return to S_IDLE. Skipped frames are not counted.
  - Header states: S_TYPE_FLAG (1 beat), then S_TIMESTAMP (2), then S_ZEROS (3), then S_PACKET_INDEX (2), then S_DATA (DATA_LENGTH).
  - S_DROP: consume beats until tlast.
- Per-frame `err` flag is cleared on header accept and set by any of:
  - flag byte not equal to 0x07;
  - a nonzero byte in S_ZEROS;
  - a data-byte mismatch;
  - tlast before the last data byte;
  - tlast missing on the last data byte;
  - tuser high on the tlast beat.
- A mismatch does not change state. Checking continues for the rest of the frame.
- Early tlast in any header or data state ends the frame and returns to S_IDLE.
- Missing tlast on the last data byte: set `err`, go to S_DROP.
- Data check:
  - The first data byte seeds `exp`, which increments modulo 2^DATA_WIDTH.
  - Each following byte is compared against `exp`. Each mismatch increments byte_error_count, then `exp` reloads from the received byte plus 1.
- Frame end is the accepted tlast beat in any non-skip state. At frame end:
  - rx_ok is set to `!err`.
  - good_frame_count or bad_frame_count increments.
  - rx_timestamp, rx_packet_index and rx_src_mac latch.
- Every counter saturates at all-ones.

## Timing
- Reset value of every output is 0, except s_eth_hdr_ready = 1. State resets to S_IDLE.
- The first payload beat can be accepted the cycle after header accept.
- Throughput is one byte per clock with no bubbles.
- rx_valid, rx_* and the counters update on the clock edge that accepts the tlast beat, so they are visible the next cycle.
- A header presented in the cycle rx_valid is high is accepted normally (back-to-back frames).
- Reset mid-frame:
  - state returns to S_IDLE and counters clear;
  - the partial frame is not reported;
  - remaining beats of that frame are not accepted until a new header is taken.

## Configuration
- TEST_CHECK_SEQ_EN defined:
  - Packet-index sequence tracking applies to rx_ok frames only. The first one after reset only seeds the tracker.
  - On later frames, a received index differing from last+1 (16-bit wrap) adds (received − expected) mod 2^16 to lost_frame_count.
  - A sequence gap does not clear rx_ok.
- TEST_CHECK_SEQ_EN undefined: lost_frame_count is tied to 0 and no tracking logic is built.

## Structure
- Shared package test_pattern_pkg holds:
  - TEST_ETH_TYPE = 16'h88B5, TEST_TYPE_FLAG = 8'h07;
  - TS_LEN = 2, ZERO_LEN = 3, IDX_LEN = 2;
  - the payload state encoding shared with the generator.
- Sub-module test_sat_counter: COUNT_WIDTH saturating counter with enable and increment-amount inputs. Four instances.

## Test plan
- Generator output with DATA_LENGTH=64, timestamp 0x1234, index 5 → rx_ok=1, rx_timestamp=0x1234, rx_packet_index=5, good_frame_count=1.
- Data byte 10 corrupted to 0xFF → rx_ok=0, byte_error_count=2 (the corrupted byte plus the next byte, which mismatches after the reload), bad_frame_count=1.
- tlast on data byte 30 → rx_ok=0, return to S_IDLE, next valid frame passes.
- Ethertype 0x0800 frame → consumed; rx_valid never pulses; counters unchanged.
- (TEST_CHECK_SEQ_EN) indices 1, 2, 5, then 0xFFFF, 0 → lost_frame_count=2 after index 5, then 65531 after 0xFFFF (2 + 65529), unchanged after 0.
- Reset asserted at payload beat 20 → all outputs 0, next frame checked cleanly.

Source files
------------

// File: rtl/test_pattern_pkg.sv
// Shared constants and payload state encoding for the test-pattern stream
// (ethertype 0x88B5), used by both the generator and the checker.
package test_pattern_pkg;

  localparam logic [15:0] TEST_ETH_TYPE  = 16'h88B5;
  localparam logic [7:0]  TEST_TYPE_FLAG = 8'h07;

  localparam int TS_LEN   = 2;
  localparam int ZERO_LEN = 3;
  localparam int IDX_LEN  = 2;
  localparam int HDR_LEN  = 1 + TS_LEN + ZERO_LEN + IDX_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_TYPE_FLAG,
    S_TIMESTAMP,
    S_ZEROS,
    S_PACKET_INDEX,
    S_DATA,
    S_DROP
  } payload_state_e;

endpackage

// File: rtl/test_sat_counter.sv
// Statistics counter that adds a variable amount when enabled and sticks
// at all-ones instead of wrapping.
module test_sat_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [COUNT_WIDTH-1:0] inc_i,
  output logic [COUNT_WIDTH-1:0] count_o
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH:0]   sum;

  // The extra carry bit of the sum detects overflow, which pins the count.
  always_comb begin
    sum     = {1'b0, count_q} + {1'b0, inc_i};
    count_d = count_q;
    if (en_i) begin
      count_d = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/test_check_pattern.sv
// Receive-side checker for the test-pattern Ethernet stream: parses the payload
// header, verifies the incrementing data and keeps saturating statistics.
// Optional packet-index loss tracking is built when TEST_CHECK_SEQ_EN is defined.
module test_check_pattern #(
  parameter int DATA_LENGTH = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [47:0]            s_eth_src_mac,
  input  logic [15:0]            s_eth_type,
  input  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
  input  logic                   s_eth_payload_axis_tvalid,
  output logic                   s_eth_payload_axis_tready,
  input  logic                   s_eth_payload_axis_tlast,
  input  logic                   s_eth_payload_axis_tuser,
  output logic                   rx_valid,
  output logic                   rx_ok,
  output logic [15:0]            rx_timestamp,
  output logic [15:0]            rx_packet_index,
  output logic [47:0]            rx_src_mac,
  output logic [COUNT_WIDTH-1:0] good_frame_count,
  output logic [COUNT_WIDTH-1:0] bad_frame_count,
  output logic [COUNT_WIDTH-1:0] byte_error_count,
  output logic [COUNT_WIDTH-1:0] lost_frame_count
);

  import test_pattern_pkg::*;

  localparam logic [15:0]            CNT_ONE   = 16'd1;
  localparam logic [15:0]            TS_LAST   = 16'(TS_LEN - 1);
  localparam logic [15:0]            ZERO_LAST = 16'(ZERO_LEN - 1);
  localparam logic [15:0]            IDX_LAST  = 16'(IDX_LEN - 1);
  localparam logic [15:0]            DATA_LAST = 16'(DATA_LENGTH - 1);
  localparam logic [DATA_WIDTH-1:0]  BYTE_ONE  = DATA_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] INC_ONE   = COUNT_WIDTH'(1);

  payload_state_e        state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d, err_now;
  logic [15:0]           ts_q, ts_d, idx_q, idx_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [47:0]           src_mac_q, src_mac_d;
  logic                  rx_valid_q, rx_valid_d, rx_ok_q, rx_ok_d;
  logic [15:0]           rx_ts_q, rx_ts_d, rx_idx_q, rx_idx_d;
  logic [47:0]           rx_src_mac_q, rx_src_mac_d;
  logic                  beat, tlast, frame_end, beat_err, early_end, byte_mismatch;
  logic [7:0]            rx_byte;
  logic                  unused_inputs;

  assign beat          = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;
  assign tlast         = s_eth_payload_axis_tlast;
  assign rx_byte       = s_eth_payload_axis_tdata[7:0];
  assign unused_inputs = ^s_eth_dest_mac;

  // Every check only raises err; the walk through the header and data states
  // is driven purely by beat counts and tlast.
  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q;
    idx_d         = idx_q;
    exp_d         = exp_q;
    src_mac_d     = src_mac_q;
    err_d         = err_q;
    rx_valid_d    = 1'b0;
    rx_ok_d       = rx_ok_q;
    rx_ts_d       = rx_ts_q;
    rx_idx_d      = rx_idx_q;
    rx_src_mac_d  = rx_src_mac_q;
    frame_end     = 1'b0;
    beat_err      = 1'b0;
    early_end     = 1'b0;
    byte_mismatch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_eth_hdr_valid) begin
          src_mac_d = s_eth_src_mac;
          err_d     = 1'b0;
          ts_d      = '0;
          idx_d     = '0;
          state_d   = (s_eth_type == TEST_ETH_TYPE) ? S_TYPE_FLAG : S_SKIP;
        end
      end
      S_SKIP: begin
        if (beat && tlast) state_d = S_IDLE;
      end
      S_TYPE_FLAG: begin
        if (beat) begin
          if (rx_byte != TEST_TYPE_FLAG) beat_err = 1'b1;
          if (tlast) early_end = 1'b1;
          else       state_d   = S_TIMESTAMP;
        end
      end
      S_TIMESTAMP: begin
        if (beat) begin
          if (cnt_q == 16'd0) ts_d[7:0]  = rx_byte;
          else                ts_d[15:8] = rx_byte;
          if (tlast)                 early_end = 1'b1;
          else if (cnt_q == TS_LAST) state_d   = S_ZEROS;
        end
      end
      S_ZEROS: begin
        if (beat) begin
          if (rx_byte != 8'h00) beat_err = 1'b1;
          if (tlast)                   early_end = 1'b1;
          else if (cnt_q == ZERO_LAST) state_d   = S_PACKET_INDEX;
        end
      end
      S_PACKET_INDEX: begin
        if (beat) begin
          if (cnt_q == 16'd0) idx_d[7:0]  = rx_byte;
          else                idx_d[15:8] = rx_byte;
          if (tlast)                  early_end = 1'b1;
          else if (cnt_q == IDX_LAST) state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          // Whether it matched or not, the next expected byte follows the received one.
          exp_d = s_eth_payload_axis_tdata + BYTE_ONE;
          if ((cnt_q != 16'd0) && (s_eth_payload_axis_tdata != exp_q)) begin
            byte_mismatch = 1'b1;
            beat_err      = 1'b1;
          end
          if (cnt_q == DATA_LAST) begin
            if (tlast) begin
              frame_end = 1'b1;
            end else begin
              beat_err = 1'b1;
              state_d  = S_DROP;
            end
          end else if (tlast) begin
            early_end = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (beat && tlast) frame_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (early_end) frame_end = 1'b1;
    err_now = err_q | beat_err | early_end | (frame_end & s_eth_payload_axis_tuser);
    if (state_q != S_IDLE) err_d = err_now;

    if (frame_end) begin
      state_d      = S_IDLE;
      rx_valid_d   = 1'b1;
      rx_ok_d      = ~err_now;
      rx_ts_d      = ts_d;
      rx_idx_d     = idx_d;
      rx_src_mac_d = src_mac_q;
    end

    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (beat)          cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ts_q         <= '0;
      idx_q        <= '0;
      exp_q        <= '0;
      src_mac_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_ok_q      <= 1'b0;
      rx_ts_q      <= '0;
      rx_idx_q     <= '0;
      rx_src_mac_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ts_q         <= ts_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      src_mac_q    <= src_mac_d;
      rx_valid_q   <= rx_valid_d;
      rx_ok_q      <= rx_ok_d;
      rx_ts_q      <= rx_ts_d;
      rx_idx_q     <= rx_idx_d;
      rx_src_mac_q <= rx_src_mac_d;
    end
  end

  assign s_eth_hdr_ready           = (state_q == S_IDLE);
  assign s_eth_payload_axis_tready = (state_q != S_IDLE);
  assign rx_valid                  = rx_valid_q;
  assign rx_ok                     = rx_ok_q;
  assign rx_timestamp              = rx_ts_q;
  assign rx_packet_index           = rx_idx_q;
  assign rx_src_mac                = rx_src_mac_q;

  test_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_good_count (
    .clk(clk), .rst(rst), .en_i(frame_end & ~err_now), .inc_i(INC_ONE), .count_o(good_frame_count)
  );

  test_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_bad_count (
    .clk(clk), .rst(rst), .en_i(frame_end & err_now), .inc_i(INC_ONE), .count_o(bad_frame_count)
  );

  test_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_byte_err_count (
    .clk(clk), .rst(rst), .en_i(byte_mismatch), .inc_i(INC_ONE), .count_o(byte_error_count)
  );

`ifdef TEST_CHECK_SEQ_EN
  logic        seq_seeded_q, seq_seeded_d;
  logic [15:0] last_idx_q, last_idx_d, exp_idx, gap;
  logic        frame_ok, lost_en;

  assign frame_ok = frame_end & ~err_now;
  assign exp_idx  = last_idx_q + CNT_ONE;
  assign gap      = idx_d - exp_idx;

  // The first good frame after reset only seeds the tracker; later good frames
  // add the modulo-2^16 distance from the expected index.
  always_comb begin
    seq_seeded_d = seq_seeded_q;
    last_idx_d   = last_idx_q;
    lost_en      = 1'b0;
    if (frame_ok) begin
      seq_seeded_d = 1'b1;
      last_idx_d   = idx_d;
      lost_en      = seq_seeded_q && (idx_d != exp_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_seeded_q <= 1'b0;
      last_idx_q   <= '0;
    end else begin
      seq_seeded_q <= seq_seeded_d;
      last_idx_q   <= last_idx_d;
    end
  end

  test_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_lost_count (
    .clk(clk), .rst(rst), .en_i(lost_en), .inc_i(COUNT_WIDTH'(gap)), .count_o(lost_frame_count)
  );
`else
  assign lost_frame_count = '0;
`endif

endmodule

// File: tb/tb_test_check_pattern.sv
// Directed, table-driven bench for test_check_pattern with hand sequences for
// mid-frame reset and (when TEST_CHECK_SEQ_EN is defined) index loss tracking.
module tb_test_check_pattern;

  import test_pattern_pkg::*;

  localparam int DATA_LENGTH = 64;
  localparam int DATA_WIDTH  = 8;
  localparam int COUNT_WIDTH = 32;
  localparam int FULL_LEN    = HDR_LEN + DATA_LENGTH;
  localparam int NUM_VECS    = 11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   s_eth_hdr_valid = 1'b0;
  logic                   s_eth_hdr_ready;
  logic [47:0]            s_eth_dest_mac = 48'hFFFF_FFFF_FFFF;
  logic [47:0]            s_eth_src_mac = '0;
  logic [15:0]            s_eth_type = '0;
  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata = '0;
  logic                   s_eth_payload_axis_tvalid = 1'b0;
  logic                   s_eth_payload_axis_tready;
  logic                   s_eth_payload_axis_tlast = 1'b0;
  logic                   s_eth_payload_axis_tuser = 1'b0;
  logic                   rx_valid, rx_ok;
  logic [15:0]            rx_timestamp, rx_packet_index;
  logic [47:0]            rx_src_mac;
  logic [COUNT_WIDTH-1:0] good_frame_count, bad_frame_count, byte_error_count, lost_frame_count;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [47:0] lastMac     = 48'h0200_0000_0000;

  typedef struct {
    logic [15:0] ethType;
    logic [7:0]  flag;
    logic [7:0]  zeroVal;
    logic [15:0] ts;
    logic [15:0] idx;
    int          corruptPos;
    logic [7:0]  corruptVal;
    int          frameLen;
    logic        tuser;
    logic        expValid;
    logic        expOk;
    int          expGood;
    int          expBad;
    int          expByteErr;
  } vec_t;

  vec_t vecs [NUM_VECS];

  test_check_pattern #(
    .DATA_LENGTH(DATA_LENGTH), .DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .rx_valid(rx_valid), .rx_ok(rx_ok), .rx_timestamp(rx_timestamp),
    .rx_packet_index(rx_packet_index), .rx_src_mac(rx_src_mac),
    .good_frame_count(good_frame_count), .bad_frame_count(bad_frame_count),
    .byte_error_count(byte_error_count), .lost_frame_count(lost_frame_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic [15:0] ethType, logic [7:0] flag, logic [7:0] zeroVal,
                                 logic [15:0] ts, logic [15:0] idx, int corruptPos,
                                 logic [7:0] corruptVal, int frameLen, logic tuser,
                                 logic expValid, logic expOk, int expGood, int expBad,
                                 int expByteErr);
    vec_t v;
    v.ethType = ethType; v.flag = flag; v.zeroVal = zeroVal; v.ts = ts; v.idx = idx;
    v.corruptPos = corruptPos; v.corruptVal = corruptVal; v.frameLen = frameLen;
    v.tuser = tuser; v.expValid = expValid; v.expOk = expOk; v.expGood = expGood;
    v.expBad = expBad; v.expByteErr = expByteErr;
    return v;
  endfunction

  function automatic logic [7:0] payloadByte(vec_t v, int i);
    int d;
    case (i)
      0:       return v.flag;
      1:       return v.ts[7:0];
      2:       return v.ts[15:8];
      4:       return v.zeroVal;
      3, 5:    return 8'h00;
      6:       return v.idx[7:0];
      7:       return v.idx[15:8];
      default: begin
        d = i - HDR_LEN;
        if (d == v.corruptPos) return v.corruptVal;
        return 8'(d);
      end
    endcase
  endfunction

  task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Takes the header (bounded wait for ready), then streams frameLen bytes with
  // no bubbles. Returns #1 after the edge that accepted the last beat.
  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    lastMac = lastMac + 48'd1;
    s_eth_src_mac   = lastMac;
    s_eth_type      = v.ethType;
    s_eth_hdr_valid = 1'b1;
    while (!s_eth_hdr_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL hdr_ready timeout: got 0, expected 1");
    end
    @(posedge clk); #1;
    s_eth_hdr_valid = 1'b0;
    for (int i = 0; i < v.frameLen; i++) begin
      s_eth_payload_axis_tdata  = payloadByte(v, i);
      s_eth_payload_axis_tvalid = 1'b1;
      s_eth_payload_axis_tlast  = (i == v.frameLen - 1);
      s_eth_payload_axis_tuser  = v.tuser && (i == v.frameLen - 1);
      @(posedge clk); #1;
    end
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    s_eth_payload_axis_tuser  = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    compare($sformatf("vec%0d rx_valid", n), 64'(rx_valid), 64'(v.expValid));
    if (v.expValid) compare($sformatf("vec%0d rx_ok", n), 64'(rx_ok), 64'(v.expOk));
    if (v.expOk) begin
      compare($sformatf("vec%0d rx_timestamp", n), 64'(rx_timestamp), 64'(v.ts));
      compare($sformatf("vec%0d rx_packet_index", n), 64'(rx_packet_index), 64'(v.idx));
      compare($sformatf("vec%0d rx_src_mac", n), 64'(rx_src_mac), 64'(lastMac));
    end
    compare($sformatf("vec%0d good_frame_count", n), 64'(good_frame_count), 64'(v.expGood));
    compare($sformatf("vec%0d bad_frame_count", n), 64'(bad_frame_count), 64'(v.expBad));
    compare($sformatf("vec%0d byte_error_count", n), 64'(byte_error_count), 64'(v.expByteErr));
`ifndef TEST_CHECK_SEQ_EN
    compare($sformatf("vec%0d lost_frame_count", n), 64'(lost_frame_count), 64'd0);
`endif
  endtask

  task automatic checkResetState(input string tag);
    compare({tag, " hdr_ready"}, 64'(s_eth_hdr_ready), 64'd1);
    compare({tag, " tready"}, 64'(s_eth_payload_axis_tready), 64'd0);
    compare({tag, " rx_valid"}, 64'(rx_valid), 64'd0);
    compare({tag, " rx_ok"}, 64'(rx_ok), 64'd0);
    compare({tag, " rx_timestamp"}, 64'(rx_timestamp), 64'd0);
    compare({tag, " rx_packet_index"}, 64'(rx_packet_index), 64'd0);
    compare({tag, " rx_src_mac"}, 64'(rx_src_mac), 64'd0);
    compare({tag, " good"}, 64'(good_frame_count), 64'd0);
    compare({tag, " bad"}, 64'(bad_frame_count), 64'd0);
    compare({tag, " byte_err"}, 64'(byte_error_count), 64'd0);
    compare({tag, " lost"}, 64'(lost_frame_count), 64'd0);
  endtask

  initial begin
    vec_t partial, seqVec;
    int   readyLeaks, validLeaks;
    logic [15:0] seqIdx  [5] = '{16'd1, 16'd2, 16'd5, 16'hFFFF, 16'd0};
    int          seqLost [5] = '{0, 0, 2, 65531, 65531};

    //                 type      flag   zero   ts        idx  cpos cval   len           tu v  ok g  b  be
    vecs[0]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'h1234, 16'd5, -1, 8'h00, FULL_LEN,     0, 1, 1, 1, 0, 0);
    vecs[1]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'h1111, 16'd6, 10, 8'hFF, FULL_LEN,     0, 1, 0, 1, 1, 2);
    vecs[2]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'h2222, 16'd7, -1, 8'h00, HDR_LEN + 31, 0, 1, 0, 1, 2, 2);
    vecs[3]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'hBEEF, 16'd8, -1, 8'h00, FULL_LEN,     0, 1, 1, 2, 2, 2);
    vecs[4]  = mkVec(16'h88B5, 8'h08, 8'h00, 16'h0001, 16'd9, -1, 8'h00, FULL_LEN,     0, 1, 0, 2, 3, 2);
    vecs[5]  = mkVec(16'h88B5, 8'h07, 8'h5A, 16'h0002, 16'd9, -1, 8'h00, FULL_LEN,     0, 1, 0, 2, 4, 2);
    vecs[6]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'h0003, 16'd9, -1, 8'h00, FULL_LEN,     1, 1, 0, 2, 5, 2);
    vecs[7]  = mkVec(16'h0800, 8'h07, 8'h00, 16'h0004, 16'd9, 3,  8'h77, FULL_LEN,     0, 0, 0, 2, 5, 2);
    vecs[8]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'hCAFE, 16'd9, -1, 8'h00, FULL_LEN,     0, 1, 1, 3, 5, 2);
    vecs[9]  = mkVec(16'h88B5, 8'h07, 8'h00, 16'h0005, 16'd9, -1, 8'h00, 4,            0, 1, 0, 3, 6, 2);
    vecs[10] = mkVec(16'h88B5, 8'h07, 8'h00, 16'h0006, 16'd9, -1, 8'h00, FULL_LEN + 3, 0, 1, 0, 3, 7, 2);

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Frames follow each other directly, so each header lands in the rx_valid cycle.
    for (int n = 0; n < NUM_VECS; n++) begin
      applyStimulus(vecs[n]);
      checkOutput(vecs[n], n);
    end

    // Reset while payload beat 20 is on the bus; the rest of that frame must be refused.
    partial = vecs[0];
    lastMac = lastMac + 48'd1;
    s_eth_src_mac   = lastMac;
    s_eth_type      = TEST_ETH_TYPE;
    s_eth_hdr_valid = 1'b1;
    @(posedge clk); #1;
    s_eth_hdr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_eth_payload_axis_tdata  = payloadByte(partial, i);
      s_eth_payload_axis_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_eth_payload_axis_tdata = payloadByte(partial, 20);
    #2 rst = 1'b1;
    #1 checkResetState("midreset");
    #3 rst = 1'b0;
    readyLeaks = 0;
    validLeaks = 0;
    for (int i = 21; i < FULL_LEN; i++) begin
      @(posedge clk); #1;
      s_eth_payload_axis_tdata = payloadByte(partial, i);
      s_eth_payload_axis_tlast = (i == FULL_LEN - 1);
      if (s_eth_payload_axis_tready) readyLeaks++;
      if (rx_valid) validLeaks++;
    end
    @(posedge clk); #1;
    if (rx_valid) validLeaks++;
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    compare("midreset tready after reset", 64'(readyLeaks), 64'd0);
    compare("midreset rx_valid after reset", 64'(validLeaks), 64'd0);
    applyStimulus(vecs[0]);
    checkOutput(mkVec(16'h88B5, 8'h07, 8'h00, 16'h1234, 16'd5, -1, 8'h00, FULL_LEN,
                      0, 1, 1, 1, 0, 0), 100);

`ifdef TEST_CHECK_SEQ_EN
    rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      seqVec = mkVec(16'h88B5, 8'h07, 8'h00, 16'h4000, seqIdx[k], -1, 8'h00, FULL_LEN,
                     0, 1, 1, k + 1, 0, 0);
      applyStimulus(seqVec);
      compare($sformatf("seq%0d rx_ok", k), 64'(rx_ok), 64'd1);
      compare($sformatf("seq%0d lost_frame_count", k), 64'(lost_frame_count), 64'(seqLost[k]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
